// File: rtl/i2c_accel_scheduler_if.sv
// Request/response bus between the accelerometer scheduler and the byte-level I2C master.
// The scheduler uses the master modport; the I2C master core (or a model of it) uses the slave modport.
interface i2c_accel_scheduler_if;
  logic       m_valid;
  logic       m_ready;
  logic       m_rnw;
  logic [6:0] m_dev_addr;
  logic [7:0] m_reg;
  logic [7:0] m_wdata;
  logic [2:0] m_len;
  logic       m_rvalid;
  logic [7:0] m_rdata;
  logic       m_done;
  logic       m_nack;

  modport master (
    output m_valid, m_rnw, m_dev_addr, m_reg, m_wdata, m_len,
    input  m_ready, m_rvalid, m_rdata, m_done, m_nack
  );

  modport slave (
    input  m_valid, m_rnw, m_dev_addr, m_reg, m_wdata, m_len,
    output m_ready, m_rvalid, m_rdata, m_done, m_nack
  );
endinterface

// File: rtl/i2c_accel_scheduler.sv
// ADXL345 sequencer: configures the sensor, polls X/Y/Z every PERIOD cycles and
// arbitrates single-register software transactions onto the shared I2C master.
module i2c_accel_scheduler #(
  parameter logic [6:0]  DEV_ADDR    = 7'h53,
  parameter int unsigned PERIOD      = 500000,
  parameter logic [7:0]  DATA_FORMAT = 8'h0B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  i2c_accel_scheduler_if.master bus,
  input  logic        sw_req,
  input  logic        sw_rnw,
  input  logic [7:0]  sw_reg,
  input  logic [7:0]  sw_wdata,
  output logic        sw_gnt,
  output logic        sw_done,
  output logic [7:0]  sw_rdata,
  output logic        sw_nack,
  output logic [15:0] x_data,
  output logic [15:0] y_data,
  output logic [15:0] z_data,
  output logic        sample_valid,
  output logic        irq,
  input  logic        irq_clr,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {INIT_PWR, INIT_FMT, IDLE, POLL, SW} state_t;

  localparam logic [23:0] TICK_AT = 24'(PERIOD - 1);

  state_t      state_q, state_d;
  logic        in_flight_q, retry_wait_q, poll_pending_q, last_sw_q;
  logic [23:0] timer_q;
  logic [2:0]  byte_cnt_q;
  logic [5:0][7:0] rx_q;

  logic tick, accept, done, capture, init_free, grant_poll, grant_sw, poll_good, err_set;
  logic       launch, launch_rnw;
  logic [7:0] launch_reg, launch_wdata;
  logic [2:0] launch_len;

  assign tick       = (timer_q == TICK_AT);
  assign accept     = bus.m_valid && bus.m_ready;
  assign done       = bus.m_done && in_flight_q;
  assign capture    = bus.m_rvalid && in_flight_q && (state_q == POLL || state_q == SW);
  assign init_free  = !bus.m_valid && !in_flight_q && !retry_wait_q;
  // Round-robin: the poll wins a conflict only if software was served last.
  assign grant_poll = (state_q == IDLE) && poll_pending_q && enable && (!sw_req || last_sw_q);
  assign grant_sw   = (state_q == IDLE) && sw_req && !grant_poll;
  assign poll_good  = !bus.m_nack && (byte_cnt_q == 3'd6);
  assign err_set    = done && ((((state_q == INIT_PWR) || (state_q == INIT_FMT)) && bus.m_nack)
                               || ((state_q == POLL) && !poll_good));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT_PWR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_PWR: if (done) state_d = bus.m_nack ? INIT_PWR : INIT_FMT;
      INIT_FMT: if (done) state_d = bus.m_nack ? INIT_PWR : IDLE;
      IDLE: begin
        if (grant_poll)    state_d = POLL;
        else if (grant_sw) state_d = SW;
      end
      POLL, SW: if (done) state_d = IDLE;
      default:  state_d = INIT_PWR;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    launch       = 1'b0;
    launch_rnw   = 1'b0;
    launch_reg   = 8'h00;
    launch_wdata = 8'h00;
    launch_len   = 3'd1;
    sw_gnt       = (state_q == SW) && accept;
    case (state_q)
      INIT_PWR: begin
        launch       = init_free;
        launch_reg   = 8'h2D;
        launch_wdata = 8'h08;
      end
      INIT_FMT: begin
        launch       = init_free;
        launch_reg   = 8'h31;
        launch_wdata = DATA_FORMAT;
      end
      IDLE: begin
        if (grant_poll) begin
          launch     = 1'b1;
          launch_rnw = 1'b1;
          launch_reg = 8'h32;
          launch_len = 3'd6;
        end else if (grant_sw) begin
          launch       = 1'b1;
          launch_rnw   = sw_rnw;
          launch_reg   = sw_reg;
          launch_wdata = sw_wdata;
        end
      end
      default: ;
    endcase
  end

  // Request fields stay registered after accept; only m_valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m_valid    <= 1'b0;
      bus.m_rnw      <= 1'b0;
      bus.m_dev_addr <= 7'h00;
      bus.m_reg      <= 8'h00;
      bus.m_wdata    <= 8'h00;
      bus.m_len      <= 3'd0;
    end else if (launch) begin
      bus.m_valid    <= 1'b1;
      bus.m_rnw      <= launch_rnw;
      bus.m_dev_addr <= DEV_ADDR;
      bus.m_reg      <= launch_reg;
      bus.m_wdata    <= launch_wdata;
      bus.m_len      <= launch_len;
    end else if (accept) begin
      bus.m_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight_q    <= 1'b0;
      retry_wait_q   <= 1'b0;
      poll_pending_q <= 1'b0;
      last_sw_q      <= 1'b1;
      timer_q        <= 24'd0;
      byte_cnt_q     <= 3'd0;
    end else begin
      timer_q <= tick ? 24'd0 : timer_q + 24'd1;
      if (accept)    in_flight_q <= 1'b1;
      else if (done) in_flight_q <= 1'b0;
      // An init nack parks the sequencer until the following tick.
      if (err_set && state_q != POLL) retry_wait_q <= 1'b1;
      else if (tick)                  retry_wait_q <= 1'b0;
      if (tick && !poll_pending_q)               poll_pending_q <= 1'b1;
      else if (accept && state_q == POLL)        poll_pending_q <= 1'b0;
      if (grant_poll)    last_sw_q <= 1'b0;
      else if (grant_sw) last_sw_q <= 1'b1;
      if (accept)                             byte_cnt_q <= 3'd0;
      else if (capture && byte_cnt_q != 3'd7) byte_cnt_q <= byte_cnt_q + 3'd1;
    end
  end

  // NOTE: the byte buffer has no reset; it is only committed after a complete, acknowledged read.
  always_ff @(posedge clk) begin
    if (capture && byte_cnt_q < 3'd6) rx_q[byte_cnt_q] <= bus.m_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_data       <= 16'h0000;
      y_data       <= 16'h0000;
      z_data       <= 16'h0000;
      sample_valid <= 1'b0;
      irq          <= 1'b0;
      err          <= 1'b0;
      sw_done      <= 1'b0;
      sw_rdata     <= 8'h00;
      sw_nack      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sw_done      <= 1'b0;
      if (done && state_q == POLL && poll_good) begin
        x_data       <= {rx_q[1], rx_q[0]};
        y_data       <= {rx_q[3], rx_q[2]};
        z_data       <= {rx_q[5], rx_q[4]};
        sample_valid <= 1'b1;
      end
      if (done && state_q == SW) begin
        sw_done <= 1'b1;
        sw_nack <= bus.m_nack;
        if (bus.m_rnw && byte_cnt_q != 3'd0) sw_rdata <= rx_q[0];
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (done && state_q == POLL && poll_good) irq <= 1'b1;
      else if (irq_clr)                         irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_accel_scheduler.sv
// Directed bench for i2c_accel_scheduler with a behavioural I2C master model
// that logs every accepted request and replies from a small response table.
module tb_i2c_accel_scheduler;
  localparam int PERIOD = 64;

  typedef struct packed {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [2:0] len;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, sw_req, sw_rnw, irq_clr, err_clr;
  logic [7:0]  sw_reg, sw_wdata, sw_rdata;
  logic        sw_gnt, sw_done, sw_nack, sample_valid, irq, err;
  logic [15:0] x_data, y_data, z_data;

  i2c_accel_scheduler_if bus();

  i2c_accel_scheduler #(.DEV_ADDR(7'h53), .PERIOD(PERIOD), .DATA_FORMAT(8'h0B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .sw_req(sw_req), .sw_rnw(sw_rnw), .sw_reg(sw_reg), .sw_wdata(sw_wdata),
    .sw_gnt(sw_gnt), .sw_done(sw_done), .sw_rdata(sw_rdata), .sw_nack(sw_nack),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_valid(sample_valid), .irq(irq), .irq_clr(irq_clr),
    .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_samples = 0, n_sw_done = 0, n_sw_gnt = 0, n_done = 0;
  txn_t log_q[$];
  int   log_cyc[$];
  logic [7:0] poll_bytes[6] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h80};
  int   poll_nbytes = 6;
  logic nack_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sample_valid) n_samples++;
    if (sw_done)      n_sw_done++;
    if (sw_gnt)       n_sw_gnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_txn(input string tag, input int idx, input logic rnw,
                           input logic [7:0] rg, input logic [7:0] wd, input logic [2:0] len);
    if (idx >= log_q.size()) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rnw"}, 32'(log_q[idx].rnw), 32'(rnw));
      check({tag, "_dev"}, 32'(log_q[idx].dev), 32'h53);
      check({tag, "_reg"}, 32'(log_q[idx].rg),  32'(rg));
      if (!rnw) check({tag, "_wdata"}, 32'(log_q[idx].wd), 32'(wd));
      check({tag, "_len"}, 32'(log_q[idx].len), 32'(len));
    end
  endtask

  // Master model: accept, go busy, return read bytes with gaps, then done.
  initial begin : master_model
    txn_t t;
    int   nb;
    bus.m_ready = 1'b1; bus.m_rvalid = 1'b0; bus.m_rdata = 8'h00;
    bus.m_done  = 1'b0; bus.m_nack   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.m_valid && bus.m_ready) begin
        t = '{bus.m_rnw, bus.m_dev_addr, bus.m_reg, bus.m_wdata, bus.m_len};
        log_q.push_back(t);
        log_cyc.push_back(cyc);
        step();
        bus.m_ready = 1'b0;
        step();
        nb = !t.rnw ? 0 : (t.rg == 8'h32) ? poll_nbytes : 1;
        for (int i = 0; i < nb; i++) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = (t.rg == 8'h32) ? poll_bytes[i] : 8'hE5;
          step();
          bus.m_rvalid = 1'b0;
          step();
        end
        bus.m_done = 1'b1;
        bus.m_nack = nack_next;
        nack_next  = 1'b0;
        step();
        bus.m_done = 1'b0;
        bus.m_nack = 1'b0;
        bus.m_ready = 1'b1;
        n_done++;
      end
    end
  end

  initial begin : main
    int t0, s0, n_reads, n_polls;
    reset = 1'b1; enable = 1'b1; sw_req = 1'b0; sw_rnw = 1'b0;
    sw_reg = 8'h00; sw_wdata = 8'h00; irq_clr = 1'b0; err_clr = 1'b0;
    repeat (3) step();
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_dev",   32'(bus.m_dev_addr), 32'd0);
    check("rst_x",       32'(x_data), 32'd0);
    check("rst_irq",     32'(irq), 32'd0);
    check("rst_err",     32'(err), 32'd0);
    check("rst_sv",      32'(sample_valid), 32'd0);
    check("rst_sw",      32'({sw_gnt, sw_done, sw_nack, sw_rdata}), 32'd0);

    // Phase A: clean init, first poll, irq, short read.
    reset = 1'b0;
    t0 = cyc;
    step();
    check("pwr_valid_lat", 32'(bus.m_valid), 32'd1);
    check("pwr_reg_live",  32'(bus.m_reg), 32'h2D);
    step();
    check("pwr_valid_drop", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 3 * PERIOD && n_samples < 1; i++) step();
    check("poll1_timeout", 32'(n_samples >= 1), 32'd1);
    check_txn("init_pwr", 0, 1'b0, 8'h2D, 8'h08, 3'd1);
    check_txn("init_fmt", 1, 1'b0, 8'h31, 8'h0B, 3'd1);
    check_txn("poll1",    2, 1'b1, 8'h32, 8'h00, 3'd6);
    if (log_cyc.size() > 2)
      check("poll1_cycle_window",
            32'((log_cyc[2] - t0) >= PERIOD && (log_cyc[2] - t0) <= PERIOD + 2), 32'd1);
    step();
    check("poll1_x", 32'(x_data), 32'h1234);
    check("poll1_y", 32'(y_data), 32'hABCD);
    check("poll1_z", 32'(z_data), 32'h8001);
    check("poll1_sv_count", 32'(n_samples), 32'd1);
    check("poll1_irq", 32'(irq), 32'd1);
    check("poll1_err", 32'(err), 32'd0);
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 32'd0);

    poll_nbytes = 4;
    for (int i = 0; i < 3 * PERIOD && n_done < 4; i++) step();
    check("short_timeout", 32'(n_done >= 4), 32'd1);
    step();
    check_txn("poll2", 3, 1'b1, 8'h32, 8'h00, 3'd6);
    check("short_x", 32'(x_data), 32'h1234);
    check("short_y", 32'(y_data), 32'hABCD);
    check("short_z", 32'(z_data), 32'h8001);
    check("short_no_sv", 32'(n_samples), 32'd1);
    check("short_err", 32'(err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr_a", 32'(err), 32'd0);
    poll_nbytes = 6;
    for (int i = 0; i < 100 && !(bus.m_ready && n_done == log_q.size()); i++) step();

    // Phase B: init nack + retry, polls held off, then poll/sw conflict.
    enable = 1'b0;
    nack_next = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    log_q.delete();
    log_cyc.delete();
    s0 = n_samples;
    reset = 1'b0;
    t0 = cyc;
    for (int i = 0; i < PERIOD && n_done < 5; i++) step();
    step();
    check("nack_err", 32'(err), 32'd1);
    check("nack_no_retry_yet", 32'(log_q.size()), 32'd1);
    while (cyc - t0 < 3 * PERIOD + 4) step();
    check("retry_log_size", 32'(log_q.size()), 32'd3);
    check_txn("retry_pwr0", 0, 1'b0, 8'h2D, 8'h08, 3'd1);
    check_txn("retry_pwr1", 1, 1'b0, 8'h2D, 8'h08, 3'd1);
    check_txn("retry_fmt",  2, 1'b0, 8'h31, 8'h0B, 3'd1);
    if (log_cyc.size() > 1)
      check("retry_after_tick", 32'((log_cyc[1] - t0) >= PERIOD), 32'd1);
    n_reads = 0;
    foreach (log_q[i]) if (log_q[i].rnw) n_reads++;
    check("disabled_no_reads", 32'(n_reads), 32'd0);
    check("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("err_clr_b", 32'(err), 32'd0);

    enable = 1'b1;
    sw_req = 1'b1; sw_rnw = 1'b1; sw_reg = 8'h00; sw_wdata = 8'h00;
    for (int i = 0; i < 200 && !sw_gnt; i++) @(negedge clk);
    check("sw_gnt_seen", 32'(sw_gnt), 32'd1);
    step();
    sw_req = 1'b0;
    for (int i = 0; i < 100 && n_sw_done < 1; i++) step();
    check("sw_done_count", 32'(n_sw_done), 32'd1);
    check("sw_gnt_count", 32'(n_sw_gnt), 32'd1);
    check_txn("conflict_poll", 3, 1'b1, 8'h32, 8'h00, 3'd6);
    check_txn("conflict_sw",   4, 1'b1, 8'h00, 8'h00, 3'd1);
    check("sw_rdata", 32'(sw_rdata), 32'hE5);
    check("sw_nack",  32'(sw_nack), 32'd0);
    n_polls = 0;
    foreach (log_q[i]) if (log_q[i].rg == 8'h32) n_polls++;
    check("one_poll_after_enable", 32'(n_polls), 32'd1);
    check("one_sample_after_enable", 32'(n_samples - s0), 32'd1);
    check("sw_err_untouched", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_accel_scheduler.md
# i2c_accel_scheduler

Hardware sequencer and arbiter for the shared I2C master that talks to the on-board ADXL345 accelerometer. After reset it configures the sensor, then reads the six X/Y/Z data bytes every PERIOD cycles and presents the samples as registers with an interrupt. Between polls it grants single-register software transactions from the Nios II side onto the same master. It sits between the Avalon-MM register wrapper (software port, sample registers, irq) and the byte-level I2C master core.

## Interface
- DEV_ADDR, 7'h53, 7-bit I2C slave address used for all transactions
- PERIOD, 500000, poll interval in clk cycles (10 ms at 50 MHz); legal range 64..2^24-1
- DATA_FORMAT, 8'h0B, value written to register 0x31 during init (full resolution, ±16 g)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  0 = no new polls are issued; software grants still proceed
- m_valid  out  1  transaction request to the I2C master; held until accepted
- m_ready  in  1  master idle; request is accepted in a cycle with m_valid=1 and m_ready=1
- m_rnw  out  1  1 = read burst, 0 = single-byte write
- m_dev_addr  out  7  always DEV_ADDR
- m_reg  out  8  register address
- m_wdata  out  8  write data
- m_len  out  3  read length in bytes (1..6); 1 for writes
- m_rvalid  in  1  one-cycle strobe per received byte
- m_rdata  in  8  received byte, valid with m_rvalid
- m_done  in  1  one-cycle end-of-transaction strobe
- m_nack  in  1  valid with m_done; 1 = slave did not acknowledge
- sw_req  in  1  software transaction request (level)
- sw_rnw, sw_reg[7:0], sw_wdata[7:0]  in  software transaction fields; stable while sw_req=1
- sw_gnt  out  1  one-cycle pulse when the software request is forwarded to the master
- sw_done  out  1  one-cycle pulse at the end of the software transaction
- sw_rdata  out  8  read byte from the last software read
- sw_nack  out  1  nack status of the last software transaction
- x_data, y_data, z_data  out  16  last good sample, two's complement, {DATAn1, DATAn0}
- sample_valid  out  1  one-cycle pulse on each sample update
- irq  out  1  level; set with sample_valid, cleared by irq_clr
- irq_clr  in  1  clears irq (set wins if coincident)
- err  out  1  sticky; nack or short read on any sequencer transaction
- err_clr  in  1  clears err (set wins if coincident)

## Operation
- States: INIT_PWR, INIT_FMT, IDLE, POLL, SW.
- Reset value: state INIT_PWR, and every output 0.
- INIT_PWR: writes 0x2D←0x08 (measure mode).
  - Done without nack → INIT_FMT. Nack → err=1, wait for the next timer tick, then retry INIT_PWR.
- INIT_FMT: writes 0x31←DATA_FORMAT.
  - Done without nack → IDLE. Nack → err=1, wait for the next timer tick, then retry INIT_PWR.
- Timer: free-running counter 0..PERIOD-1. The tick occurs at PERIOD-1.
  - Tick sets poll_pending. A tick while poll_pending is already set is dropped; polls do not queue.
- IDLE arbitration:
  - Request sources are poll_pending (only when enable=1) and sw_req.
  - If both are pending, round-robin: the source not served last wins. After reset, software is treated as served last, so the first conflict goes to the poll.
  - No software grants are made before init completes.
- POLL: issues a read of m_reg=0x32, m_len=6. poll_pending clears on accept.
  - Bytes are stored in order X0, X1, Y0, Y1, Z0, Z1.
  - On m_done with m_nack=0 and exactly 6 m_rvalid strobes: x/y/z update together, and sample_valid pulses.
  - Otherwise: the data registers are kept and err=1.
  - Extra strobes beyond 6 are ignored and count as an error.
- SW: forwards the software fields with m_len=1. sw_gnt pulses in the accept cycle.
  - For a read, sw_rdata captures m_rdata.
  - At m_done: sw_nack ← m_nack, sw_done pulses. Software errors do not set err.
  - sw_req must be dropped after sw_gnt. If it is still high in IDLE, it is a new request.
- Any transaction returns to IDLE after m_done.

## Timing
- m_valid goes high one cycle after the arbitration decision, with all m_* fields registered and stable until accept.
- m_valid drops in the cycle after accept.
- sample_valid, sw_done and the new sw_rdata/sw_nack/x/y/z values all appear one cycle after m_done.
- irq rises with sample_valid.
- Reset mid-transaction: returns to INIT_PWR and drops m_valid in the same edge. The master shares this reset.
- m_done while not in POLL or SW is ignored.

## Test plan
- Reset release with master model always acking, sequence observed:
  - write 0x2D←0x08, then write 0x31←0x0B, each accepted one cycle after m_ready;
  - then, at cycle PERIOD after reset release, a read of 0x32 with len 6.
- Poll returning bytes 34 12 CD AB 01 80 → x=0x1234, y=0xABCD, z=0x8001, one sample_valid pulse, irq=1; irq_clr → irq=0.
- Nack on INIT_PWR → err=1, no reads issued; retry after the next tick succeeds; err stays set until err_clr.
- sw_req (read 0x00) and poll_pending in the same IDLE cycle → poll is granted first, then the software read; sw_rdata=0xE5, sw_done pulse, sw_nack=0.
- Poll with only 4 m_rvalid strobes before m_done → x/y/z unchanged, err=1, no sample_valid.
- enable=0 across three ticks → no polls. enable=1 with the tick already pending → exactly one poll.
